// File: rtl/board_io_pkg.sv
// Shared defaults and types for the board I/O front-end.
package board_io_pkg;

  localparam int BOARD_IO_NUM_IN           = 5;
  localparam int BOARD_IO_NUM_LED          = 8;
  localparam int BOARD_IO_DEBOUNCE_CYCLES  = 1000000;
  localparam int BOARD_IO_PWM_W            = 8;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } io_edge_t;

endpackage

// File: rtl/io_debouncer.sv
// Single-channel pad conditioner: 2-FF synchroniser, debounce counter and
// one-cycle edge pulses aligned with the first cycle of the new level.
module io_debouncer
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_IO_DEBOUNCE_CYCLES
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pad_i,
  output io_edge_t edge_o
);

  localparam int               CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return to the stable value clears the count, so bounces restart it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_TC) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pad_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_o.level = stable_q;
  assign edge_o.rise  = rise_q;
  assign edge_o.fall  = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// Board pad front-end: debounced GPIO inputs and LED drive.
// BOARD_IO_LED_PWM_EN adds global PWM dimming; otherwise LEDs follow led_en.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_IN          = BOARD_IO_NUM_IN,
  parameter int NUM_LED         = BOARD_IO_NUM_LED,
  parameter int DEBOUNCE_CYCLES = BOARD_IO_DEBOUNCE_CYCLES,
  parameter int PWM_W           = BOARD_IO_PWM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  pad_in,
  output logic [NUM_IN-1:0]  in_level,
  output logic [NUM_IN-1:0]  in_rise,
  output logic [NUM_IN-1:0]  in_fall,
  input  logic [NUM_LED-1:0] led_en,
  input  logic [PWM_W-1:0]   led_brightness,
  output logic [NUM_LED-1:0] pad_led
);

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_edge_t edge_w;

    io_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (pad_in[g]),
      .edge_o (edge_w)
    );

    assign in_level[g] = edge_w.level;
    assign in_rise[g]  = edge_w.rise;
    assign in_fall[g]  = edge_w.fall;
  end

  logic [NUM_LED-1:0] pad_led_q, pad_led_d;

`ifdef BOARD_IO_LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic             duty_on;

  // Brightness is only sampled at the wrap so a period is never cut short.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    shadow_d  = (pwm_cnt_q == '1) ? led_brightness : shadow_q;
    duty_on   = (shadow_q == '1) || (pwm_cnt_q < shadow_q);
    pad_led_d = led_en & {NUM_LED{duty_on}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      shadow_q  <= shadow_d;
    end
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^led_brightness;
  assign pad_led_d         = led_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_led_q <= '0;
    end else begin
      pad_led_q <= pad_led_d;
    end
  end

  assign pad_led = pad_led_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Scoreboard bench for board_io_conditioner (DEBOUNCE_CYCLES=16, PWM_W=4).
module tb_board_io_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pad_in;
  logic [4:0] in_level, in_rise, in_fall;
  logic [7:0] led_en;
  logic [3:0] led_brightness;
  logic [7:0] pad_led;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
`ifdef BOARD_IO_LED_PWM_EN
  int rst_edge = 0;
`endif

  typedef struct {
    int         due;
    logic [4:0] lvl;
    logic [4:0] rise;
    logic [4:0] fall;
  } dbn_exp_t;

  typedef struct {
    int         due;
    logic [7:0] led;
  } led_exp_t;

  dbn_exp_t dq[$];
  led_exp_t lq[$];

  board_io_conditioner #(
    .NUM_IN          (5),
    .NUM_LED         (8),
    .DEBOUNCE_CYCLES (16),
    .PWM_W           (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pad_in         (pad_in),
    .in_level       (in_level),
    .in_rise        (in_rise),
    .in_fall        (in_fall),
    .led_en         (led_en),
    .led_brightness (led_brightness),
    .pad_led        (pad_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    int c0;
    dbn_exp_t de;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_level, in_rise, in_fall, pad_led} !== 23'h0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got lvl=%h rise=%h fall=%h led=%h exp all 0",
                 cyc, in_level, in_rise, in_fall, pad_led);
      end
    end
    rst = 1'b0;
    c0 = cyc;
    for (int c = c0 + 1; c <= c0 + 20; c++)
      dq.push_back('{c, (c >= c0 + 18) ? 5'h1F : 5'h00, (c == c0 + 18) ? 5'h1F : 5'h00, 5'h00});
    repeat (20) begin
      @(negedge clk);
      while (dq.size() != 0 && dq[0].due <= cyc) begin
        de = dq.pop_front();
        checks++;
        if (de.due != cyc || in_level !== de.lvl || in_rise !== de.rise || in_fall !== de.fall) begin
          errors++;
          $display("FAIL reset_release cyc=%0d got lvl=%h rise=%h fall=%h exp lvl=%h rise=%h fall=%h",
                   cyc, in_level, in_rise, in_fall, de.lvl, de.rise, de.fall);
        end
      end
    end
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL reset_timeout pending=%0d exp 0", dq.size());
      dq.delete();
    end
  endtask

  task automatic test_bounce();
    int cs;
    dbn_exp_t de;
    pad_in = 5'h00;
    repeat (20) @(negedge clk);
    cs = cyc;
    // final rising edge is driven at cs+13, so the level lands at cs+31
    for (int c = cs + 1; c <= cs + 35; c++)
      dq.push_back('{c, (c >= cs + 31) ? 5'h01 : 5'h00, (c == cs + 31) ? 5'h01 : 5'h00, 5'h00});
    fork
      begin
        pad_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        pad_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        pad_in[0] = 1'b1;
      end
      begin
        repeat (35) begin
          @(negedge clk);
          while (dq.size() != 0 && dq[0].due <= cyc) begin
            de = dq.pop_front();
            checks++;
            if (de.due != cyc || in_level !== de.lvl || in_rise !== de.rise || in_fall !== de.fall) begin
              errors++;
              $display("FAIL bounce cyc=%0d got lvl=%h rise=%h fall=%h exp lvl=%h rise=%h fall=%h",
                       cyc, in_level, in_rise, in_fall, de.lvl, de.rise, de.fall);
            end
          end
        end
      end
    join
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL bounce_timeout pending=%0d exp 0", dq.size());
      dq.delete();
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    dbn_exp_t de;
    pad_in = 5'h09;
    repeat (20) @(negedge clk);
    pad_in = 5'h03;
    c0 = cyc;
    for (int c = c0 + 1; c <= c0 + 20; c++)
      dq.push_back('{c, (c >= c0 + 18) ? 5'h03 : 5'h09, (c == c0 + 18) ? 5'h02 : 5'h00,
                     (c == c0 + 18) ? 5'h08 : 5'h00});
    repeat (20) begin
      @(negedge clk);
      while (dq.size() != 0 && dq[0].due <= cyc) begin
        de = dq.pop_front();
        checks++;
        if (de.due != cyc || in_level !== de.lvl || in_rise !== de.rise || in_fall !== de.fall) begin
          errors++;
          $display("FAIL simultaneous cyc=%0d got lvl=%h rise=%h fall=%h exp lvl=%h rise=%h fall=%h",
                   cyc, in_level, in_rise, in_fall, de.lvl, de.rise, de.fall);
        end
      end
    end
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL simultaneous_timeout pending=%0d exp 0", dq.size());
      dq.delete();
    end
  endtask

  task automatic test_reset_midcount();
    int c0;
    dbn_exp_t de;
    c0 = cyc;
    // counter reaches 10 at edge c0+12; reset edge is c0+13
    for (int c = c0 + 1; c <= c0 + 33; c++)
      dq.push_back('{c, (c <= c0 + 12) ? 5'h03 : ((c >= c0 + 31) ? 5'h07 : 5'h00),
                     (c == c0 + 31) ? 5'h07 : 5'h00, 5'h00});
    fork
      begin
        pad_in = 5'h07;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef BOARD_IO_LED_PWM_EN
        rst_edge = cyc;
`endif
      end
      begin
        repeat (33) begin
          @(negedge clk);
          while (dq.size() != 0 && dq[0].due <= cyc) begin
            de = dq.pop_front();
            checks++;
            if (de.due != cyc || in_level !== de.lvl || in_rise !== de.rise || in_fall !== de.fall) begin
              errors++;
              $display("FAIL reset_midcount cyc=%0d got lvl=%h rise=%h fall=%h exp lvl=%h rise=%h fall=%h",
                       cyc, in_level, in_rise, in_fall, de.lvl, de.rise, de.fall);
            end
          end
        end
      end
    join
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL reset_midcount_timeout pending=%0d exp 0", dq.size());
      dq.delete();
    end
  endtask

  task automatic test_led();
    led_exp_t le;
    logic [7:0] exp_led;
`ifdef BOARD_IO_LED_PWM_EN
    logic [3:0] sh_m = 4'd0;
    int         cnt_now;
    int         hi_a = 0, hi_b = 0, hi_c = 0;
    logic       mid = 1'b0;
`endif
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      while (lq.size() != 0 && lq[0].due <= cyc) begin
        le = lq.pop_front();
        checks++;
        if (le.due != cyc || pad_led !== le.led) begin
          errors++;
          $display("FAIL led cyc=%0d got pad_led=%h exp %h", cyc, pad_led, le.led);
        end
      end
`ifdef BOARD_IO_LED_PWM_EN
      if (k >= 20 && k < 36)   hi_a += int'(pad_led[0]);
      if (k >= 60 && k < 76)   hi_b += int'(pad_led[0]);
      if (k >= 100 && k < 116) hi_c += int'(pad_led[0]);
      cnt_now = (cyc - rst_edge) % 16;
      if (k >= 160 && cnt_now == 7) mid = 1'b1;
      if (k < 200) begin
        led_en = 8'h01;
        if (k < 40)       led_brightness = 4'd4;
        else if (k < 80)  led_brightness = 4'd0;
        else if (k < 120) led_brightness = 4'd15;
        else              led_brightness = mid ? 4'd12 : 4'd4;
      end else begin
        led_en         = 8'($urandom);
        led_brightness = 4'd9;
      end
      exp_led = led_en & {8{(sh_m == 4'hF) || (cnt_now < int'(sh_m))}};
      if (cnt_now == 15) sh_m = led_brightness;
`else
      led_en         = (k == 0) ? 8'hA5 : 8'($urandom);
      led_brightness = 4'($urandom_range(15, 0));
      exp_led        = led_en;
`endif
      lq.push_back('{cyc + 1, exp_led});
    end
    @(negedge clk);
    while (lq.size() != 0 && lq[0].due <= cyc) begin
      le = lq.pop_front();
      checks++;
      if (le.due != cyc || pad_led !== le.led) begin
        errors++;
        $display("FAIL led cyc=%0d got pad_led=%h exp %h", cyc, pad_led, le.led);
      end
    end
    if (lq.size() != 0) begin
      checks++; errors++;
      $display("FAIL led_timeout pending=%0d exp 0", lq.size());
      lq.delete();
    end
`ifdef BOARD_IO_LED_PWM_EN
    checks++;
    if (hi_a != 4) begin errors++; $display("FAIL duty_4 got %0d high of 16 exp 4", hi_a); end
    checks++;
    if (hi_b != 0) begin errors++; $display("FAIL duty_0 got %0d high of 16 exp 0", hi_b); end
    checks++;
    if (hi_c != 16) begin errors++; $display("FAIL duty_15 got %0d high of 16 exp 16", hi_c); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    pad_in         = 5'h1F;
    led_en         = 8'h00;
    led_brightness = 4'd0;
    test_reset();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_led();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_io_conditioner.md
Name: board_io_conditioner

Overview:
- Parametrised board-level I/O front-end placed between the FPGA board pads and the SoC GPIO bus.
- Inputs: synchronises and debounces NUM_IN raw pad inputs (buttons and switches), then provides the stable level plus one-cycle rise and fall pulses to gpio_in.
- Outputs: drives NUM_LED board LEDs from gpio_out enables, with global PWM brightness control.
- Generalises the fixed 4-button/1-switch/4-LED wiring to any channel count and adds debounce, edge detection and dimming.

Parameters:
- NUM_IN, 5, number of raw pad inputs.
- NUM_LED, 8, number of LED outputs.
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a level is accepted; 10 ms at 100 MHz; must be >= 2.
- PWM_W, 8, width of the PWM counter and of the brightness value.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- pad_in  input  NUM_IN  raw asynchronous pad levels.
- in_level  output  NUM_IN  debounced stable level.
- in_rise  output  NUM_IN  one-cycle pulse when in_level goes 0->1.
- in_fall  output  NUM_IN  one-cycle pulse when in_level goes 1->0.
- led_en  input  NUM_LED  per-LED enable from gpio_out.
- led_brightness  input  PWM_W  global duty value.
- pad_led  output  NUM_LED  LED pad drive.

Behaviour:
- Reset: all registers clear on the clk edge while rst=1. This covers synchroniser flops, stable levels, debounce counters, the PWM counter and the brightness shadow. in_level, in_rise, in_fall and pad_led are 0. Reset mid-count discards the partial count.
- Synchroniser: 2-FF synchroniser per input; sync[i] is pad_in delayed by 2 cycles.
- Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES):
  - If sync == stable, the counter clears.
  - Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while sync != stable, stable takes sync on that edge and the counter clears.
  - Any bounce back to the stable value before terminal count restarts the count from 0.
- Latency: a clean pad edge reaches in_level after 2 + DEBOUNCE_CYCLES cycles.
- Edge pulses: in_rise and in_fall are asserted for exactly one cycle, in the same cycle in_level first shows the new value. They are never both high on one channel. Channels are fully independent, and simultaneous events on several channels produce simultaneous pulses.
- PWM counter: free-running PWM_W-bit counter that wraps from 2^PWM_W-1 to 0.
- Brightness shadow: led_brightness is captured into the shadow register only in the cycle the counter wraps to 0, so mid-period changes never glitch. The first shadow load after reset occurs at the first wrap.
- LED drive: pad_led[i] is registered.
  - pad_led[i] = led_en[i] & (shadow == all-ones | pwm_cnt < shadow).
  - shadow = 0 gives always off.
  - shadow = all-ones gives always on (100 %).
  - Otherwise the duty is shadow / 2^PWM_W.
  - led_en changes take effect one cycle later, independent of the PWM phase.

Optional Feature:
- Macro: BOARD_IO_LED_PWM_EN.
- Defined: PWM counter, brightness shadow and duty gating are present, as described above.
- Undefined: no PWM logic. pad_led[i] = led_en[i], registered with 1-cycle latency. led_brightness is unused and no counter is instantiated.

Decomposition:
- Package board_io_pkg holds:
  - default constants BOARD_IO_NUM_IN, BOARD_IO_NUM_LED, BOARD_IO_DEBOUNCE_CYCLES and BOARD_IO_PWM_W;
  - typedef io_edge_t, a struct {level, rise, fall}.
- Sub-module io_debouncer: single channel containing the synchroniser, debounce counter and edge pulses, parametrised by DEBOUNCE_CYCLES. The top instantiates it NUM_IN times with a generate loop.
- LED/PWM logic stays in the top.

Test Plan:
- All tests use DEBOUNCE_CYCLES=16 and PWM_W=4.
- Reset: hold rst 3 cycles with pad_in=5'h1F -> all outputs 0 during reset. After release, in_level=5'h1F at cycle 18, with in_rise=5'h1F for exactly one cycle.
- Bounce rejection: pad_in[0] toggles high for 10 cycles, low for 3, then high steadily -> in_level[0] rises exactly 18 cycles after the final rising edge, with one in_rise pulse and no in_fall.
- Simultaneous events: pad_in[1] rises and pad_in[3] falls in the same cycle -> in_rise[1] and in_fall[3] pulse in the same cycle, 18 cycles later.
- Reset mid-count: pad_in[2] goes high, rst pulses at count 10 -> in_level[2] rises 18 cycles after rst is released, not earlier.
- PWM duty (macro defined): led_en=8'h01, brightness=4 -> pad_led[0] high 4 of every 16 cycles. Brightness 0 -> constantly low. Brightness 15 -> constantly high. A change written mid-period takes effect only at the next wrap.
- Macro undefined: led_en=8'hA5 -> pad_led=8'hA5 one cycle later, with led_brightness ignored.
